// File: rtl/page_walker.sv
// page_walker: Sv39 hardware page-table walker that refills a TLB on a miss.
// Walks up to three PTE levels and emits a 4 KiB translation or a fault pulse.
module page_walker #(
   parameter int PA_BITS = 56
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        clear,
   input  logic        req,
   input  logic [63:0] va,
   input  logic [43:0] root_ppn,
   output logic        busy,
   output logic        mem_req,
   output logic [63:0] mem_addr,
   input  logic        mem_ack,
   input  logic        mem_rsp_valid,
   input  logic [63:0] mem_rsp_data,
   output logic        done,
   output logic        fault,
   output logic        replace,
   output logic [63:0] replace_va,
   output logic [63:0] replace_pa,
   output logic        replace_dirty,
   output logic        replace_readable,
   output logic        replace_writable
);
   typedef enum logic [2:0] {IDLE, REQ, WAIT, DONE, FAULT} state_t;
   localparam logic [63:0] pa_mask = {{(64 - PA_BITS){1'b0}}, {PA_BITS{1'b1}}};
   state_t state;
   logic [1:0] level;
   logic [63:12] va_q;
   logic [43:0] ppn, pte_ppn, pa_ppn;
   logic [8:0] vpn_next;
   logic abort, leaf_d, leaf_r, leaf_w;
   logic pte_leaf, misaligned, pte_fault;
   logic unused_bits;
   assign unused_bits = ^{va[11:0], mem_rsp_data[63:54], mem_rsp_data[9:8], mem_rsp_data[5:4]};
   assign busy = state != IDLE;
   assign pte_ppn = mem_rsp_data[53:10];
   assign pte_leaf = mem_rsp_data[1] | mem_rsp_data[3];
   assign misaligned = level == 2'd2 ? |pte_ppn[17:0] : level == 2'd1 ? |pte_ppn[8:0] : 1'b0;
   assign pte_fault = !mem_rsp_data[0] | (!mem_rsp_data[1] & mem_rsp_data[2])
                    | (!pte_leaf & level == 2'd0) | (pte_leaf & (misaligned | !mem_rsp_data[6]));
   assign vpn_next = level == 2'd2 ? va_q[29:21] : va_q[20:12];
   // Superpages are split down to the 4 KiB page that missed.
   assign pa_ppn = level == 2'd2 ? {ppn[43:18], va_q[29:12]} : level == 2'd1 ? {ppn[43:9], va_q[20:12]} : ppn;
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
         level <= 2'd2;
         va_q <= '0;
         ppn <= '0;
         abort <= 1'b0;
         leaf_d <= 1'b0;
         leaf_r <= 1'b0;
         leaf_w <= 1'b0;
         mem_req <= 1'b0;
         mem_addr <= '0;
         done <= 1'b0;
         fault <= 1'b0;
         replace <= 1'b0;
         replace_va <= '0;
         replace_pa <= '0;
         replace_dirty <= 1'b0;
         replace_readable <= 1'b0;
         replace_writable <= 1'b0;
      end else begin
         done <= 1'b0;
         fault <= 1'b0;
         replace <= 1'b0;
         replace_va <= '0;
         replace_pa <= '0;
         replace_dirty <= 1'b0;
         replace_readable <= 1'b0;
         replace_writable <= 1'b0;
         case (state)
            IDLE: if (req && !clear) begin
               va_q <= va[63:12];
               level <= 2'd2;
               abort <= 1'b0;
               if (va[63:39] != {25{va[38]}}) state <= FAULT;
               else begin
                  state <= REQ;
                  mem_req <= 1'b1;
                  mem_addr <= {8'b0, root_ppn, va[38:30], 3'b000};
               end
            end
            REQ: if (mem_ack) begin
               state <= WAIT;
               mem_req <= 1'b0;
               abort <= clear;
            end else if (clear) begin
               state <= IDLE;
               mem_req <= 1'b0;
            end
            // An aborted read must still be drained before going idle.
            WAIT: if (mem_rsp_valid) begin
               if (abort || clear) state <= IDLE;
               else if (pte_fault) state <= FAULT;
               else if (!pte_leaf) begin
                  state <= REQ;
                  level <= level - 2'd1;
                  mem_req <= 1'b1;
                  mem_addr <= {8'b0, pte_ppn, vpn_next, 3'b000};
               end else begin
                  state <= DONE;
                  ppn <= pte_ppn;
                  leaf_d <= mem_rsp_data[7];
                  leaf_r <= mem_rsp_data[1];
                  leaf_w <= mem_rsp_data[2];
               end
            end else if (clear) abort <= 1'b1;
            DONE: begin
               state <= IDLE;
               if (!clear) begin
                  done <= 1'b1;
                  replace <= 1'b1;
                  replace_va <= {va_q, 12'h0};
                  replace_pa <= {8'b0, pa_ppn, 12'h0} & pa_mask;
                  replace_dirty <= leaf_d;
                  replace_readable <= leaf_r;
                  replace_writable <= leaf_w;
               end
            end
            FAULT: begin
               state <= IDLE;
               done <= !clear;
               fault <= !clear;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_page_walker.sv
// tb_page_walker: directed and randomized walks checked against an arithmetic Sv39 model.
module tb_page_walker;
   logic clk = 0, reset = 0, clear = 0, req = 0, mem_ack = 0, mem_rsp_valid = 0;
   logic [63:0] va = 0, mem_rsp_data = 0;
   logic [43:0] root_ppn = 0;
   logic busy, mem_req, done, fault, replace, replace_dirty, replace_readable, replace_writable;
   logic [63:0] mem_addr, replace_va, replace_pa;
   int checks = 0, errors = 0, cyc = 0;
   int ack_dly = 0, rsp_dly = 1, ack_wait = 0, rsp_cnt = 0, n_reads = 0, n_done = 0;
   int start_cyc = 0, done_cyc = 0;
   logic [63:0] rsp_addr, last_pa, last_va;
   logic last_d, last_f, saw_req;
   typedef struct packed {
      logic f;
      logic [63:0] pa;
      logic [63:0] va;
      logic d, r, w;
   } res_t;
   res_t exp_res_q[$];
   res_t e;
   logic [63:0] exp_addr_q[$];
   logic [63:0] model_addrs[$];
   logic [63:0] mem[logic [63:0]];

   page_walker dut (
      .clk(clk), .reset(reset), .clear(clear), .req(req), .va(va), .root_ppn(root_ppn),
      .busy(busy), .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack),
      .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data), .done(done), .fault(fault),
      .replace(replace), .replace_va(replace_va), .replace_pa(replace_pa),
      .replace_dirty(replace_dirty), .replace_readable(replace_readable),
      .replace_writable(replace_writable)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [63:0] rd(input logic [63:0] a);
      return mem.exists(a) ? mem[a] : 64'h0;
   endfunction

   function automatic res_t ref_walk(input logic [63:0] v, input logic [43:0] root);
      res_t r;
      logic [63:0] base, pte, sz, pbase;
      r = '0;
      r.f = 1'b1;
      r.va = v - (v % 4096);
      model_addrs.delete();
      if ((v >> 38) != 0 && (v >> 38) != 64'h3ff_ffff) return r;
      base = 64'(root) * 4096;
      for (int lvl = 2; lvl >= 0; lvl--) begin
         model_addrs.push_back(base + ((v >> (12 + 9 * lvl)) % 512) * 8);
         pte = rd(model_addrs[model_addrs.size() - 1]);
         sz = 64'd1 << (12 + 9 * lvl);
         pbase = ((pte >> 10) % (64'd1 << 44)) * 4096;
         if (pte[0] == 1'b0 || (pte[1] == 1'b0 && pte[2] == 1'b1)) return r;
         if (pte[1] == 1'b0 && pte[3] == 1'b0) begin
            if (lvl == 0) return r;
            base = pbase;
         end else begin
            if (pbase % sz != 0 || pte[6] == 1'b0) return r;
            r.f = 1'b0;
            r.pa = pbase + (v % sz) - (v % 4096);
            r.d = pte[7];
            r.r = pte[1];
            r.w = pte[2];
            return r;
         end
      end
      return r;
   endfunction

   // Memory: ack after ack_dly waiting cycles, response rsp_dly cycles after the ack.
   initial forever begin
      @(posedge clk);
      #1;
      mem_ack = 0;
      mem_rsp_valid = 0;
      mem_rsp_data = 0;
      if (rsp_cnt > 0) begin
         rsp_cnt--;
         if (rsp_cnt == 0) begin
            mem_rsp_valid = 1;
            mem_rsp_data = rd(rsp_addr);
         end
      end
      if (mem_req) begin
         if (ack_wait >= ack_dly) begin
            mem_ack = 1;
            ack_wait = 0;
            rsp_cnt = rsp_dly;
            rsp_addr = mem_addr;
            n_reads++;
            if (exp_addr_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL mem_req: unexpected read at %h", mem_addr);
            end else chk("mem_addr", mem_addr, exp_addr_q.pop_front());
         end else ack_wait++;
      end else ack_wait = 0;
   end

   always @(negedge clk) if (reset) begin
      if (mem_req) saw_req = 1;
      if (done) begin
         n_done++;
         done_cyc = cyc;
         last_pa = replace_pa;
         last_va = replace_va;
         last_d = replace_dirty;
         last_f = fault;
         if (exp_res_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL done: unexpected done, fault=%0b replace=%0b", fault, replace);
         end else begin
            e = exp_res_q.pop_front();
            chk("fault", 64'(fault), 64'(e.f));
            chk("replace", 64'(replace), 64'(!e.f));
            if (!e.f) begin
               chk("replace_pa", replace_pa, e.pa);
               chk("replace_va", replace_va, e.va);
               chk("replace_dirty", 64'(replace_dirty), 64'(e.d));
               chk("replace_readable", 64'(replace_readable), 64'(e.r));
               chk("replace_writable", 64'(replace_writable), 64'(e.w));
            end
         end
      end else chk("pulse_without_done", 64'({fault, replace}), 64'd0);
   end

   task automatic launch(input logic [63:0] v, input logic [43:0] root, input bit expect_done);
      res_t r;
      r = ref_walk(v, root);
      foreach (model_addrs[i]) exp_addr_q.push_back(model_addrs[i]);
      if (expect_done) exp_res_q.push_back(r);
      @(posedge clk);
      #1;
      va = v;
      root_ppn = root;
      req = 1;
      start_cyc = cyc;
      @(posedge clk);
      #1;
      req = 0;
   endtask

   task automatic wait_idle(input string name);
      int n;
      n = 0;
      while ((exp_res_q.size() != 0 || busy || rsp_cnt != 0) && n < 300) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (n >= 300) begin
         errors++;
         $display("FAIL %s: timeout, walk did not end", name);
         exp_res_q.delete();
      end
      repeat (2) @(negedge clk);
      chk({name, "_reads_left"}, 64'(exp_addr_q.size()), 64'd0);
      exp_addr_q.delete();
   endtask

   task automatic setup_4k(input logic [63:0] l0);
      mem.delete();
      mem[64'h100008] = (64'h200 << 10) | 64'h1;
      mem[64'h200808] = (64'h300 << 10) | 64'h1;
      mem[64'h300808] = l0;
   endtask

   task automatic fault_case(input string name, input logic [63:0] v, input int reads);
      res_t r;
      r = ref_walk(v, 44'h100);
      chk({name, "_model"}, 64'({r.f, 8'(model_addrs.size())}), 64'({1'b1, 8'(reads)}));
      n_reads = 0;
      launch(v, 44'h100, 1);
      wait_idle(name);
      chk({name, "_reads"}, 64'(n_reads), 64'(reads));
      chk({name, "_fault"}, 64'(last_f), 64'd1);
   endtask

   initial begin : stim
      res_t r;
      logic [63:0] v, base, a, p;
      logic [43:0] root, ppn;
      logic [2:0] rwx;
      int k, nd;
      bit stop;
      repeat (3) @(negedge clk);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_mem_req", 64'(mem_req), 64'd0);
      chk("rst_pulses", 64'({done, fault, replace}), 64'd0);
      chk("rst_mem_addr", mem_addr, 64'd0);
      chk("rst_replace_pa", replace_pa, 64'd0);
      @(posedge clk);
      #1 reset = 1;

      setup_4k((64'h80000 << 10) | 64'hC7);
      r = ref_walk(64'h6030_1abc, 44'h100);
      chk("model_4k_pa", r.pa, 64'h8000_0000);
      chk("model_4k_addr0", model_addrs[0], 64'h100008);
      chk("model_4k_addr2", model_addrs[2], 64'h300808);
      ack_dly = 0;
      rsp_dly = 1;
      n_reads = 0;
      launch(64'h6030_1abc, 44'h100, 1);
      wait_idle("4k");
      chk("4k_latency", 64'(done_cyc - start_cyc), 64'd8);
      chk("4k_pa", last_pa, 64'h8000_0000);
      chk("4k_va", last_va, 64'h6030_1000);
      chk("4k_dirty", 64'(last_d), 64'd1);
      chk("4k_reads", 64'(n_reads), 64'd3);

      mem.delete();
      mem[64'h100000] = (64'h40000 << 10) | 64'h4F;
      r = ref_walk(64'h1234_5678, 44'h100);
      chk("model_1g_pa", r.pa, 64'h5234_5000);
      n_reads = 0;
      launch(64'h1234_5678, 44'h100, 1);
      wait_idle("1g");
      chk("1g_reads", 64'(n_reads), 64'd1);
      chk("1g_pa", last_pa, 64'h5234_5000);
      chk("1g_dirty", 64'(last_d), 64'd0);

      mem.delete();
      fault_case("f_l2_zero", 64'h6030_1abc, 1);
      setup_4k(64'h1);
      fault_case("f_l0_nonleaf", 64'h6030_1abc, 3);
      setup_4k(64'h0);
      mem[64'h200808] = (64'h201 << 10) | 64'hCF;
      fault_case("f_misaligned", 64'h6030_1abc, 2);
      setup_4k((64'h80000 << 10) | 64'h87);
      fault_case("f_a0", 64'h6030_1abc, 3);

      saw_req = 0;
      fault_case("f_noncanon", 64'h0000_0080_0000_0000, 0);
      chk("noncanon_latency", 64'(done_cyc - start_cyc), 64'd2);
      chk("noncanon_no_mem_req", 64'(saw_req), 64'd0);

      setup_4k((64'h80000 << 10) | 64'hC7);
      rsp_dly = 4;
      nd = n_done;
      n_reads = 0;
      launch(64'h6030_1abc, 44'h100, 0);
      @(posedge clk);
      #1 clear = 1;
      @(posedge clk);
      #1 clear = 0;
      while (cyc < start_cyc + 5) @(negedge clk);
      chk("abort_busy_at_rsp", 64'(busy), 64'd1);
      @(negedge clk);
      chk("abort_busy_after_rsp", 64'(busy), 64'd0);
      exp_addr_q.delete();
      repeat (4) @(negedge clk);
      chk("abort_no_done", 64'(n_done - nd), 64'd0);
      chk("abort_reads", 64'(n_reads), 64'd1);
      rsp_dly = 1;
      launch(64'h6030_1abc, 44'h100, 1);
      wait_idle("after_abort");
      chk("after_abort_pa", last_pa, 64'h8000_0000);

      rsp_dly = 3;
      nd = n_done;
      launch(64'h6030_1abc, 44'h100, 0);
      @(negedge clk);
      reset = 0;
      #1;
      chk("rst_mid_busy", 64'(busy), 64'd0);
      chk("rst_mid_outs", 64'({mem_req, done, fault, replace}), 64'd0);
      chk("rst_mid_addr", mem_addr, 64'd0);
      @(posedge clk);
      #1 reset = 1;
      exp_addr_q.delete();
      saw_req = 0;
      repeat (4) begin
         @(negedge clk);
         chk("stale_rsp_busy", 64'(busy), 64'd0);
      end
      chk("stale_rsp_no_done", 64'(n_done - nd), 64'd0);
      chk("stale_rsp_no_req", 64'(saw_req), 64'd0);

      rsp_dly = 2;
      nd = n_done;
      n_reads = 0;
      launch(64'h6030_1abc, 44'h100, 1);
      repeat (2) @(posedge clk);
      #1;
      va = 64'h1234_5678;
      req = 1;
      @(posedge clk);
      #1 req = 0;
      wait_idle("req_busy");
      chk("req_busy_one_done", 64'(n_done - nd), 64'd1);
      chk("req_busy_reads", 64'(n_reads), 64'd3);

      nd = n_done;
      saw_req = 0;
      @(posedge clk);
      #1;
      va = 64'h6030_1abc;
      req = 1;
      clear = 1;
      @(posedge clk);
      #1;
      req = 0;
      clear = 0;
      @(negedge clk);
      chk("clear_req_busy", 64'(busy), 64'd0);
      repeat (3) @(negedge clk);
      chk("clear_req_no_mem", 64'(saw_req), 64'd0);
      chk("clear_req_no_done", 64'(n_done - nd), 64'd0);

      for (int t = 0; t < 80; t++) begin
         mem.delete();
         root = 44'($urandom_range(1, 32'hfffff));
         v = {$urandom, $urandom};
         if ($urandom_range(0, 7) != 0) v[63:39] = {25{v[38]}};
         base = 64'(root) << 12;
         stop = 0;
         for (int lvl = 2; lvl >= 0 && !stop; lvl--) begin
            a = base + ((v >> (12 + 9 * lvl)) % 512) * 8;
            k = $urandom_range(0, 9);
            if (k <= 3) begin
               ppn = 44'($urandom_range(1, 32'hfffff));
               p = (64'(ppn) << 10) | 64'h1;
               base = 64'(ppn) << 12;
            end else begin
               stop = 1;
               if (k <= 7) begin
                  ppn = 44'({$urandom, $urandom});
                  if (k != 7) ppn = ppn - (ppn % (44'd1 << (9 * lvl)));
                  rwx = 3'($urandom);
                  if (rwx == 3'b000) rwx = 3'b001;
                  p = (64'(ppn) << 10) | 64'({1'($urandom), 1'($urandom_range(0, 5) != 0), 2'($urandom), rwx, 1'b1});
               end else p = {$urandom, $urandom} & (k == 8 ? ~64'h1 : ~64'h0);
            end
            mem[a] = p;
         end
         ack_dly = $urandom_range(0, 2);
         rsp_dly = $urandom_range(1, 3);
         launch(v, root, 1);
         wait_idle("rand");
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
